// File: rtl/egress_push_scheduler_if.sv
// Push-bus bundle between the per-port egress queues, the scheduler and the converter bank.
// master = scheduler side, slave = queue/converter side.
interface egress_push_scheduler_if #(
    parameter int nbrOfPorts     = 4,
    parameter int parrallelWidth = 512,
    parameter int infoWidth      = 16
);
    localparam int portWidth = (nbrOfPorts > 1) ? $clog2(nbrOfPorts) : 1;

    logic                                          enable;
    logic [nbrOfPorts-1:0]                         reqValid;
    logic [nbrOfPorts-1:0][parrallelWidth-1:0]     reqData;
    logic [nbrOfPorts-1:0][infoWidth-1:0]          reqInfo;
    logic [nbrOfPorts-1:0]                         reqSof;
    logic [nbrOfPorts-1:0]                         reqEof;
    logic [nbrOfPorts-1:0]                         reqReady;
    logic [nbrOfPorts-1:0]                         full;
    logic                                          push;
    logic [portWidth-1:0]                          pushPort;
    logic [parrallelWidth-1:0]                     pushData;
    logic [infoWidth-1:0]                          pushInfo;
    logic                                          idle;
    logic                                          protocolError;

    modport master (
        input  enable, reqValid, reqData, reqInfo, reqSof, reqEof, full,
        output reqReady, push, pushPort, pushData, pushInfo, idle, protocolError
    );

    modport slave (
        output enable, reqValid, reqData, reqInfo, reqSof, reqEof, full,
        input  reqReady, push, pushPort, pushData, pushInfo, idle, protocolError
    );
endinterface

// File: rtl/egress_push_scheduler.sv
// Round-robin arbiter of egress queues onto the converter push bus; word appears on push one cycle after transfer.
// Backpressure: converter full flag plus a per-port holdoff keep a port ungranted; disable drains open frames only.
module egress_push_scheduler #(
    parameter int nbrOfPorts     = 4,
    parameter int parrallelWidth = 512,
    parameter int infoWidth      = 16,
    parameter int holdoff        = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    egress_push_scheduler_if.master   bus
);
    localparam int PW = (nbrOfPorts > 1) ? $clog2(nbrOfPorts) : 1;

    localparam logic [1:0] STOPPED = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;

    logic [1:0]                  state;
    logic [PW-1:0]               ptr;
    logic [nbrOfPorts-1:0][2:0]  hold;
    logic [nbrOfPorts-1:0]       in_frame;
    logic [nbrOfPorts-1:0]       state_mask;
    logic [nbrOfPorts-1:0]       eligible;
    logic [nbrOfPorts-1:0]       grant_oh;
    logic                        grant_any;
    logic [PW-1:0]               grant_idx;
    logic                        sof_g;
    logic                        eof_g;
    logic                        in_frame_g;

    always_comb begin
        case (state)
            RUN:     state_mask = '1;
            DRAIN:   state_mask = in_frame;
            default: state_mask = '0;
        endcase
    end

    always_comb begin
        for (int i = 0; i < nbrOfPorts; i++) begin
            eligible[i] = bus.reqValid[i] & ~bus.full[i] & (hold[i] == 3'd0) & state_mask[i];
        end
    end

    // Walk upward from ptr with wrap; the first eligible port wins.
    always_comb begin
        int j;
        grant_any = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        j         = 0;
        for (int k = 0; k < nbrOfPorts; k++) begin
            j = int'(ptr) + k;
            if (j >= nbrOfPorts) j = j - nbrOfPorts;
            if (!grant_any && eligible[j]) begin
                grant_any = 1'b1;
                grant_idx = PW'(j);
            end
        end
        if (grant_any) grant_oh[grant_idx] = 1'b1;
    end

    assign bus.reqReady = grant_oh;
    assign sof_g        = bus.reqSof[grant_idx];
    assign eof_g        = bus.reqEof[grant_idx];
    assign in_frame_g   = in_frame[grant_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.push          <= 1'b0;
            bus.pushPort      <= '0;
            bus.pushData      <= '0;
            bus.pushInfo      <= '0;
            bus.protocolError <= 1'b0;
            ptr               <= '0;
            in_frame          <= '0;
        end else begin
            bus.push <= grant_any;
            // A lone sof+eof on a closed port is a legal single-word frame.
            bus.protocolError <= grant_any & ((sof_g & in_frame_g) | (eof_g & ~sof_g & ~in_frame_g));
            if (grant_any) begin
                bus.pushPort <= grant_idx;
                bus.pushData <= bus.reqData[grant_idx];
                bus.pushInfo <= bus.reqInfo[grant_idx];
                ptr          <= (grant_idx == PW'(nbrOfPorts - 1)) ? '0 : grant_idx + PW'(1);
                if (eof_g)      in_frame[grant_idx] <= 1'b0;
                else if (sof_g) in_frame[grant_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
        end else begin
            for (int i = 0; i < nbrOfPorts; i++) begin
                if (grant_any && grant_idx == PW'(i)) hold[i] <= 3'(holdoff);
                else if (hold[i] != 3'd0)             hold[i] <= hold[i] - 3'd1;
            end
        end
    end

    // Leave DRAIN only once every frame is closed and its last word has left the push register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= STOPPED;
            bus.idle <= 1'b1;
        end else begin
            bus.idle <= (state == STOPPED);
            case (state)
                STOPPED: if (bus.enable) state <= RUN;
                RUN:     if (!bus.enable) state <= DRAIN;
                DRAIN: begin
                    if (bus.enable)                           state <= RUN;
                    else if (in_frame == '0 && !bus.push)     state <= STOPPED;
                end
                default: state <= STOPPED;
            endcase
        end
    end
endmodule
